wb_post_wrbuf: RTL and testbench

- Wishbone posted-write buffer placed directly upstream of the SDRAM controller top's Wishbone slave port.
- Acknowledges CPU writes after one cycle, queues them, and drains them to the controller in order.
- Reads are held until every queued write has drained, then passed through, so read-after-write ordering is preserved.
- Hides SDRAM write latency from a classic-cycle Wishbone master.

---
 rtl/wb_post_pkg.sv | 15 +
 rtl/wb_post_fifo.sv | 64 ++++++
 rtl/wb_post_wrbuf.sv | 182 ++++++++++++++++++
 tb/tb_wb_post_wrbuf.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_post_pkg.sv
// Shared constants, defaults and FSM state encoding for the wb_post_wrbuf posted-write buffer.
package wb_post_pkg;
    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 30;
    localparam int ENTRY_W = AW_DEF + DW_DEF + DW_DEF / 8;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_RESP
    } state_e;
endpackage

// File: rtl/wb_post_fifo.sv
// Circular queue of posted write entries; when WB_POST_MERGE_EN is defined the
// most recently pushed (tail) entry can be rewritten in place.
module wb_post_fifo #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
`ifdef WB_POST_MERGE_EN
    input  logic             tail_wr,
    input  logic [W-1:0]     tail_data,
    output logic [W-1:0]     tail,
`endif
    output logic [W-1:0]     head,
    output logic [DEPTH_W:0] count
);
    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       mem_d [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_W'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_W'(pop);
        count_d  = count_q + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(pop);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
`ifdef WB_POST_MERGE_EN
        else if (tail_wr) begin
            mem_d[wr_ptr_q - DEPTH_W'(1)] = tail_data;
        end
`endif
    end

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
`ifdef WB_POST_MERGE_EN
    assign tail  = mem_q[wr_ptr_q - DEPTH_W'(1)];
`endif
endmodule

// File: rtl/wb_post_wrbuf.sv
// Wishbone posted-write buffer: acks writes after one cycle, drains them in order,
// and holds reads until the queue is empty. Define WB_POST_MERGE_EN to merge same-address writes into the tail.
module wb_post_wrbuf
    import wb_post_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                s_wb_cyc_i,
    input  logic                s_wb_stb_i,
    input  logic                s_wb_we_i,
    input  logic [AW-1:0]       s_wb_addr_i,
    input  logic [DW-1:0]       s_wb_dat_i,
    input  logic [DW/8-1:0]     s_wb_sel_i,
    output logic                s_wb_ack_o,
    output logic [DW-1:0]       s_wb_dat_o,
    output logic                m_wb_cyc_o,
    output logic                m_wb_stb_o,
    output logic                m_wb_we_o,
    output logic [AW-1:0]       m_wb_addr_o,
    output logic [DW-1:0]       m_wb_dat_o,
    output logic [DW/8-1:0]     m_wb_sel_o,
    output logic [2:0]          m_wb_cti_o,
    input  logic                m_wb_ack_i,
    input  logic [DW-1:0]       m_wb_dat_i,
    output logic                buf_empty_o,
    output logic [DEPTH_W:0]    buf_count_o
);
    localparam int SW = DW / 8;
    localparam int EW = AW + DW + SW;
    localparam logic [DEPTH_W:0] CNT_FULL = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0] CNT_ONE  = (DEPTH_W+1)'(1);

    state_e           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             ack_q, ack_d;
    logic             abort_q, abort_d;
    logic [DW-1:0]    rdat_q, rdat_d;

    logic             new_req, new_wr, new_rd;
    logic             push, pop, merge;
    logic [EW-1:0]    head;
    logic [DEPTH_W:0] count;

    assign new_req = s_wb_cyc_i & s_wb_stb_i & ~ack_q;
    assign new_wr  = new_req & s_wb_we_i;
    assign new_rd  = new_req & ~s_wb_we_i;
    assign pop     = (state_q == ST_WRITE) & cyc_q & m_wb_ack_i;
    assign push    = new_wr & ~merge & (count < CNT_FULL);

`ifdef WB_POST_MERGE_EN
    logic [EW-1:0] tail;
    logic [EW-1:0] tail_data;
    logic [DW-1:0] merged_dat;

    // The entry being driven downstream is never rewritten, so merging into a lone head in WRITE is blocked.
    always_comb begin
        merged_dat = tail[SW +: DW];
        for (int i = 0; i < SW; i++) begin
            if (s_wb_sel_i[i]) begin
                merged_dat[i*8 +: 8] = s_wb_dat_i[i*8 +: 8];
            end
        end
        tail_data = {tail[EW-1 -: AW], merged_dat, tail[SW-1:0] | s_wb_sel_i};
        merge     = new_wr && (count != '0) && (tail[EW-1 -: AW] == s_wb_addr_i)
                    && !((state_q == ST_WRITE) && (count == CNT_ONE));
    end
`else
    assign merge = 1'b0;
`endif

    wb_post_fifo #(
        .W       (EW),
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data ({s_wb_addr_i, s_wb_dat_i, s_wb_sel_i}),
        .pop       (pop),
`ifdef WB_POST_MERGE_EN
        .tail_wr   (merge),
        .tail_data (tail_data),
        .tail      (tail),
`endif
        .head      (head),
        .count     (count)
    );

    // Between queued entries cyc drops for one cycle, giving each write its own classic cycle.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        abort_d = abort_q;
        rdat_d  = rdat_q;
        ack_d   = push | merge;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (count != '0) begin
                    state_d = ST_WRITE;
                    cyc_d   = 1'b1;
                end else if (new_rd) begin
                    state_d = ST_READ;
                    cyc_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                end else if (m_wb_ack_i) begin
                    cyc_d = 1'b0;
                    if (count == CNT_ONE && !push) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (!s_wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (m_wb_ack_i) begin
                    cyc_d   = 1'b0;
                    rdat_d  = m_wb_dat_i;
                    ack_d   = s_wb_cyc_i & ~abort_q;
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            ack_q   <= 1'b0;
            abort_q <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        m_wb_addr_o = '0;
        m_wb_dat_o  = '0;
        m_wb_sel_o  = '0;
        if (state_q == ST_WRITE) begin
            m_wb_addr_o = head[EW-1 -: AW];
            m_wb_dat_o  = head[SW +: DW];
            m_wb_sel_o  = head[SW-1:0];
        end else if (state_q == ST_READ) begin
            m_wb_addr_o = s_wb_addr_i;
            m_wb_sel_o  = s_wb_sel_i;
        end
    end

    assign m_wb_cyc_o  = cyc_q;
    assign m_wb_stb_o  = cyc_q;
    assign m_wb_we_o   = cyc_q & (state_q == ST_WRITE);
    assign m_wb_cti_o  = CTI_CLASSIC;
    assign s_wb_ack_o  = ack_q;
    assign s_wb_dat_o  = rdat_q;
    assign buf_count_o = count;
    assign buf_empty_o = (count == '0) && (state_q == ST_IDLE);
endmodule

// File: tb/tb_wb_post_wrbuf.sv
// Self-checking bench for wb_post_wrbuf: table vectors, directed corner sequences,
// and a randomized run checked against a transaction-order reference model.
module tb_wb_post_wrbuf;
    localparam int DW      = 32;
    localparam int AW      = 30;
    localparam int SW      = DW / 8;
    localparam int DEPTH   = 4;
    localparam int DEPTH_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_cyc, s_stb, s_we;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_dat;
    logic [SW-1:0]      s_sel;
    logic               s_ack;
    logic [DW-1:0]      s_rdat;
    logic               m_cyc, m_stb, m_we;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_dat;
    logic [SW-1:0]      m_sel;
    logic [2:0]         m_cti;
    logic               m_ack;
    logic [DW-1:0]      m_rdat;
    logic               buf_empty;
    logic [DEPTH_W:0]   buf_count;

    wb_post_wrbuf #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .s_wb_cyc_i  (s_cyc),
        .s_wb_stb_i  (s_stb),
        .s_wb_we_i   (s_we),
        .s_wb_addr_i (s_addr),
        .s_wb_dat_i  (s_dat),
        .s_wb_sel_i  (s_sel),
        .s_wb_ack_o  (s_ack),
        .s_wb_dat_o  (s_rdat),
        .m_wb_cyc_o  (m_cyc),
        .m_wb_stb_o  (m_stb),
        .m_wb_we_o   (m_we),
        .m_wb_addr_o (m_addr),
        .m_wb_dat_o  (m_dat),
        .m_wb_sel_o  (m_sel),
        .m_wb_cti_o  (m_cti),
        .m_wb_ack_i  (m_ack),
        .m_wb_dat_i  (m_rdat),
        .buf_empty_o (buf_empty),
        .buf_count_o (buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } txn_t;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [DW-1:0]    dat;
        logic [SW-1:0]    sel;
        int               delay;
        int               expLat;
        logic [DEPTH_W:0] expCnt;
    } vec_t;

    int   checksTotal = 0;
    int   checksPassed = 0;
    int   orderViolations = 0;
    int   ackPulses = 0;
    bit   slvStall = 1'b0;
    int   slvDelay = 0;
    int   waitCnt;
    logic [DW-1:0] slvData;
    txn_t downLog[$];
    txn_t expQ[$];

    // Controller model: acks after slvDelay waiting cycles and records every completed downstream cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_ack   <= 1'b0;
            waitCnt <= 0;
        end else begin
            m_ack <= 1'b0;
            if (m_cyc && m_stb && !m_ack && !slvStall) begin
                if (waitCnt >= slvDelay) begin
                    slvData = $urandom;
                    m_ack   <= 1'b1;
                    m_rdat  <= slvData;
                    waitCnt <= 0;
                    downLog.push_back('{we: m_we, addr: m_addr, dat: (m_we ? m_dat : slvData), sel: m_sel});
                end else begin
                    waitCnt <= waitCnt + 1;
                end
            end
        end
    end

    // A downstream read must never be in progress while writes are still queued.
    always @(posedge clk) begin
        if (!rst && m_cyc && !m_we && buf_count != 0) orderViolations = orderViolations + 1;
        if (s_ack) ackPulses = ackPulses + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    endtask

    task automatic doReset();
        rst = 1'b1;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_addr = '0; s_dat = '0; s_sel = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wbWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] sel,
                           input int maxCyc, output int lat);
        if (s_ack) begin
            @(posedge clk); #1;
        end
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        s_addr = a; s_dat = d; s_sel = sel;
        lat = -1;
        for (int n = 1; n <= maxCyc; n++) begin
            @(posedge clk); #1;
            if (s_ack) begin
                lat = n;
                break;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    task automatic wbRead(input logic [AW-1:0] a, input logic [SW-1:0] sel, input int maxCyc,
                          output int lat, output logic [DW-1:0] d);
        if (s_ack) begin
            @(posedge clk); #1;
        end
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
        s_addr = a; s_sel = sel;
        lat = -1;
        d = '0;
        for (int n = 1; n <= maxCyc; n++) begin
            @(posedge clk); #1;
            if (s_ack) begin
                lat = n;
                d = s_rdat;
                break;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < maxCyc; n++) begin
            @(posedge clk); #1;
            if (buf_empty && !m_cyc) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        bit ok;
        slvDelay = v.delay;
        downLog.delete();
        wbWrite(v.addr, v.dat, v.sel, 10, lat);
        checkOutput("vecAckLatency", lat, v.expLat);
        checkOutput("vecCountAfterAck", buf_count, v.expCnt);
        waitIdle(100, ok);
        checkOutput("vecDrained", ok, 1);
        checkOutput("vecDownCount", downLog.size(), 1);
        if (downLog.size() > 0) begin
            checkOutput("vecDownWe", downLog[0].we, 1);
            checkOutput("vecDownAddr", downLog[0].addr, v.addr);
            checkOutput("vecDownData", downLog[0].dat, v.dat);
            checkOutput("vecDownSel", downLog[0].sel, v.sel);
        end
        checkOutput("vecCountEnd", buf_count, 0);
    endtask

    initial begin
        vec_t vecs[4];
        int lat;
        bit ok;
        bit sawAck;
        int logAtAck;
        int ackBase;
        logic [DW-1:0] rd;

        vecs[0] = '{addr: 30'h100,      dat: 32'hA5A5_1234, sel: 4'hF, delay: 5, expLat: 1, expCnt: 3'd1};
        vecs[1] = '{addr: 30'h3FFF_FFFF, dat: 32'hFFFF_FFFF, sel: 4'h1, delay: 0, expLat: 1, expCnt: 3'd1};
        vecs[2] = '{addr: 30'h0,        dat: 32'h0000_0000, sel: 4'h0, delay: 2, expLat: 1, expCnt: 3'd1};
        vecs[3] = '{addr: 30'h155,      dat: 32'hDEAD_BEEF, sel: 4'hA, delay: 1, expLat: 1, expCnt: 3'd1};

        doReset();
        $display("[TB] reset values");
        checkOutput("rstAck", s_ack, 0);
        checkOutput("rstRdData", s_rdat, 0);
        checkOutput("rstCyc", m_cyc, 0);
        checkOutput("rstStb", m_stb, 0);
        checkOutput("rstWe", m_we, 0);
        checkOutput("rstAddr", m_addr, 0);
        checkOutput("rstDat", m_dat, 0);
        checkOutput("rstSel", m_sel, 0);
        checkOutput("rstCti", m_cti, 0);
        checkOutput("rstCount", buf_count, 0);
        checkOutput("rstEmpty", buf_empty, 1);

        $display("[TB] single-write vectors");
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        $display("[TB] full queue with stalled controller");
        slvStall = 1'b1;
        slvDelay = 0;
        downLog.delete();
        for (int i = 0; i < 4; i++) begin
            wbWrite(AW'(32'h500 + i), 32'h1000_0000 + i, 4'hF, 10, lat);
            checkOutput("fillAckLatency", lat, 1);
        end
        checkOutput("fullCount", buf_count, 4);
        @(posedge clk); #1;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        s_addr = AW'(32'h504); s_dat = 32'h1000_0004; s_sel = 4'hF;
        sawAck = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (s_ack) sawAck = 1'b1;
        end
        checkOutput("fullNoAck", sawAck, 0);
        checkOutput("fullHeld", buf_count, 4);
        slvStall = 1'b0;
        sawAck = 1'b0;
        logAtAck = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (s_ack) begin
                sawAck = 1'b1;
                logAtAck = downLog.size();
                break;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        checkOutput("fifthAcked", sawAck, 1);
        checkOutput("fifthAfterFirstDrain", logAtAck >= 1, 1);
        waitIdle(200, ok);
        checkOutput("fullDrained", ok, 1);
        checkOutput("fullDownCount", downLog.size(), 5);
        for (int i = 0; i < 5 && i < downLog.size(); i++) begin
            checkOutput("fullOrderAddr", downLog[i].addr, AW'(32'h500 + i));
            checkOutput("fullOrderData", downLog[i].dat, 32'h1000_0000 + i);
        end

        $display("[TB] read after write");
        slvDelay = 3;
        downLog.delete();
        wbWrite(30'h200, 32'h1111_1111, 4'hF, 10, lat);
        checkOutput("rawWrLatency", lat, 1);
        wbRead(30'h200, 4'hF, 60, lat, rd);
        checkOutput("rawReadDone", lat > 0, 1);
        @(posedge clk); #1;
        checkOutput("rawSingleAck", s_ack, 0);
        checkOutput("rawDownCount", downLog.size(), 2);
        if (downLog.size() == 2) begin
            checkOutput("rawFirstIsWrite", downLog[0].we, 1);
            checkOutput("rawWriteData", downLog[0].dat, 32'h1111_1111);
            checkOutput("rawSecondIsRead", downLog[1].we, 0);
            checkOutput("rawReadAddr", downLog[1].addr, 30'h200);
            checkOutput("rawReadData", rd, downLog[1].dat);
        end

        $display("[TB] reset with queued writes");
        slvStall = 1'b1;
        downLog.delete();
        for (int i = 0; i < 3; i++) wbWrite(AW'(32'h600 + i), 32'h2222_0000 + i, 4'hF, 10, lat);
        @(posedge clk); #1;
        checkOutput("preRstCyc", m_cyc, 1);
        checkOutput("preRstCount", buf_count, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midRstCyc", m_cyc, 0);
        checkOutput("midRstCount", buf_count, 0);
        checkOutput("midRstEmpty", buf_empty, 1);
        rst = 1'b0;
        slvStall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midRstNoDrain", downLog.size(), 0);

        $display("[TB] upstream abandons a read");
        slvDelay = 4;
        downLog.delete();
        ackBase = ackPulses;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = 30'h2AA; s_sel = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abortReadCyc", m_cyc && !m_we, 1);
        s_cyc = 1'b0; s_stb = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("abortNoAck", ackPulses - ackBase, 0);
        checkOutput("abortDownDone", downLog.size(), 1);
        checkOutput("abortIdle", buf_empty, 1);

`ifdef WB_POST_MERGE_EN
        $display("[TB] write merging into tail");
        slvStall = 1'b1;
        slvDelay = 0;
        downLog.delete();
        wbWrite(30'h400, 32'h4444_4444, 4'hF, 10, lat);
        wbWrite(30'h300, 32'h0000_BEEF, 4'h3, 10, lat);
        wbWrite(30'h300, 32'hCAFE_0000, 4'hC, 10, lat);
        checkOutput("mergeAckLatency", lat, 1);
        checkOutput("mergeCount", buf_count, 2);
        slvStall = 1'b0;
        waitIdle(100, ok);
        checkOutput("mergeDrained", ok, 1);
        checkOutput("mergeDownCount", downLog.size(), 2);
        if (downLog.size() == 2) begin
            checkOutput("mergeAddr", downLog[1].addr, 30'h300);
            checkOutput("mergeData", downLog[1].dat, 32'hCAFE_BEEF);
            checkOutput("mergeSel", downLog[1].sel, 4'hF);
        end
`endif

        $display("[TB] randomized traffic");
        downLog.delete();
        expQ.delete();
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] d;
            logic [SW-1:0] sel;
            logic [AW-1:0] a;
            slvDelay = $urandom_range(0, 3);
            sel = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) begin
                a = AW'(32'h1000 + i);
                d = $urandom;
                wbWrite(a, d, sel, 60, lat);
                checkOutput("rndWriteAcked", lat > 0, 1);
                expQ.push_back('{we: 1'b1, addr: a, dat: d, sel: sel});
            end else begin
                a = AW'($urandom_range(0, 32'h3FF));
                wbRead(a, sel, 100, lat, d);
                checkOutput("rndReadAcked", lat > 0, 1);
                expQ.push_back('{we: 1'b0, addr: a, dat: d, sel: sel});
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        waitIdle(300, ok);
        checkOutput("rndDrained", ok, 1);
        checkOutput("rndDownCount", downLog.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < downLog.size(); i++) begin
            checkOutput("rndWe", downLog[i].we, expQ[i].we);
            checkOutput("rndAddr", downLog[i].addr, expQ[i].addr);
            checkOutput("rndSel", downLog[i].sel, expQ[i].sel);
            checkOutput("rndData", downLog[i].dat, expQ[i].dat);
        end

        checkOutput("readOrderInvariant", orderViolations, 0);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
